// File: rtl/snd_out_pkg.sv
// Shared types, widths and the 16-bit saturation helper for the sound output stage.
// Imported by snd_out_stage; holds no logic of its own.
package snd_out_pkg;

    localparam int DECIM_DEF    = 73;
    localparam int RECIP_DEF    = 898;
    localparam int DC_SHIFT_DEF = 10;
    localparam int ACC_W        = 24;
    localparam int YF_W         = 32;
    localparam int WIDE_W       = 48;

    localparam logic signed [WIDE_W-1:0] S16_MAX = 48'sd32767;
    localparam logic signed [WIDE_W-1:0] S16_MIN = -48'sd32768;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AVG  = 2'd1,
        DCB  = 2'd2,
        GAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [15:0] value;
        logic               clipped;
    } sat_t;

    function automatic sat_t sat16(input logic signed [WIDE_W-1:0] v);
        sat_t r;
        if (v > S16_MAX) begin
            r.value   = 16'sh7fff;
            r.clipped = 1'b1;
        end else if (v < S16_MIN) begin
            r.value   = 16'sh8000;
            r.clipped = 1'b1;
        end else begin
            r.value   = v[15:0];
            r.clipped = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/snd_out_stage.sv
// Sound output stage: boxcar decimation, DC-blocking high-pass, master gain/mute with
// saturation. One output sample per decimated block, three cycles after the block completes.
module snd_out_stage
    import snd_out_pkg::*;
#(
    parameter int DECIM    = DECIM_DEF,
    parameter int RECIP    = RECIP_DEF,
    parameter int DC_SHIFT = DC_SHIFT_DEF
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce_in,
    input  logic signed [15:0] sample_in,
    input  logic        [7:0]  gain,
    input  logic               mute,
    output logic signed [15:0] sample_out,
    output logic               sample_valid,
    output logic               clip
);

    localparam logic [7:0]  CNT_LAST = 8'(DECIM - 1);
    localparam logic [16:0] RECIP_U  = 17'(RECIP);
    localparam logic signed [WIDE_W-1:0] YF_MAX =
        WIDE_W'((longint'(1) <<< (16 + DC_SHIFT)) - longint'(1));
    localparam logic signed [WIDE_W-1:0] YF_MIN = -YF_MAX;

    logic signed [ACC_W-1:0]  r_acc;
    logic        [7:0]        r_cnt;
    logic signed [ACC_W-1:0]  r_hold;
    state_t                   r_state;
    logic signed [15:0]       r_x;
    logic signed [15:0]       r_x1;
    logic signed [YF_W-1:0]   r_yf;
    logic signed [15:0]       r_d;

    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_block_done;
    logic signed [WIDE_W-1:0] w_avg_prod;
    sat_t                     w_avg_sat;
    logic signed [WIDE_W-1:0] w_diff;
    logic signed [WIDE_W-1:0] w_yf_ext;
    logic signed [WIDE_W-1:0] w_yf_calc;
    logic signed [WIDE_W-1:0] w_yf_sat;
    logic                     w_yf_clip;
    sat_t                     w_d_sat;
    logic signed [WIDE_W-1:0] w_gain_prod;
    sat_t                     w_gain_sat;

    assign w_acc_next   = r_acc + ACC_W'(sample_in);
    assign w_block_done = ce_in && (r_cnt == CNT_LAST);

    // NOTE: sequential state uses <= only so every block sees pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_hold <= '0;
        end else if (ce_in) begin
            if (w_block_done) begin
                r_hold <= w_acc_next;
                r_acc  <= '0;
                r_cnt  <= '0;
            end else begin
                r_acc  <= w_acc_next;
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    assign w_avg_prod = WIDE_W'(r_hold) * $signed(WIDE_W'(RECIP_U));
    assign w_avg_sat  = sat16(w_avg_prod >>> 16);

    assign w_diff    = WIDE_W'(r_x) - WIDE_W'(r_x1);
    assign w_yf_ext  = WIDE_W'(r_yf);
    assign w_yf_calc = (w_diff <<< DC_SHIFT) + w_yf_ext - (w_yf_ext >>> DC_SHIFT);

    // NOTE: every always_comb output gets a default first, so no latch can be inferred.
    always_comb begin
        w_yf_sat  = w_yf_calc;
        w_yf_clip = 1'b0;
        if (w_yf_calc > YF_MAX) begin
            w_yf_sat  = YF_MAX;
            w_yf_clip = 1'b1;
        end else if (w_yf_calc < YF_MIN) begin
            w_yf_sat  = YF_MIN;
            w_yf_clip = 1'b1;
        end
    end

    assign w_d_sat     = sat16(w_yf_sat >>> DC_SHIFT);
    assign w_gain_prod = WIDE_W'(r_d) * $signed(WIDE_W'({1'b0, gain}));
    assign w_gain_sat  = sat16(w_gain_prod >>> 7);

    // A block completing outside IDLE restarts AVG on the freshly captured hold value.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_x1         <= '0;
            r_yf         <= '0;
            r_d          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            clip         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            unique case (r_state)
                IDLE: r_state <= IDLE;
                AVG: begin
                    r_x     <= w_avg_sat.value;
                    r_state <= DCB;
                    if (w_avg_sat.clipped) clip <= 1'b1;
                end
                DCB: begin
                    r_yf    <= w_yf_sat[YF_W-1:0];
                    r_x1    <= r_x;
                    r_d     <= w_d_sat.value;
                    r_state <= GAIN;
                    if (w_yf_clip || w_d_sat.clipped) clip <= 1'b1;
                end
                GAIN: begin
                    sample_out   <= mute ? 16'sd0 : w_gain_sat.value;
                    sample_valid <= 1'b1;
                    r_state      <= IDLE;
                    if (!mute && w_gain_sat.clipped) clip <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_block_done) r_state <= AVG;
        end
    end

endmodule

// File: tb/tb_snd_out_stage.sv
// Scoreboard bench for snd_out_stage: a default build (DECIM=73) and a DECIM=5 build
// share data/gain/mute/reset; each has its own ce_in.
module tb_snd_out_stage;

    logic               clk_sys = 1'b0;
    logic               reset;
    logic               ce0, ce1;
    logic signed [15:0] sample_in;
    logic        [7:0]  gain;
    logic               mute;
    logic signed [15:0] out0, out1;
    logic               val0, val1, clip0, clip1;

    always #5 clk_sys = ~clk_sys;

    snd_out_stage u_dut0 (
        .clk_sys(clk_sys), .reset(reset), .ce_in(ce0), .sample_in(sample_in),
        .gain(gain), .mute(mute), .sample_out(out0), .sample_valid(val0), .clip(clip0)
    );

    snd_out_stage #(.DECIM(5), .RECIP(13107), .DC_SHIFT(10)) u_dut1 (
        .clk_sys(clk_sys), .reset(reset), .ce_in(ce1), .sample_in(sample_in),
        .gain(gain), .mute(mute), .sample_out(out1), .sample_valid(val1), .clip(clip1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    typedef struct {
        int     inst;
        longint val;
        bit     clp;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc[2], m_x1[2], m_yf[2];
    int     m_cnt[2];
    bit     m_clip[2];
    int     vcount[2];
    longint last_out[2];

    localparam longint YF_LIM = (longint'(1) << 26) - 1;

    function automatic longint clampv(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = 0; m_x1[i] = 0; m_yf[i] = 0; m_cnt[i] = 0; m_clip[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_block(input int i, input longint hold);
        longint recip, xr, x, yfr, yf, dr, d, orr, o;
        bit c;
        recip = (i == 0) ? 898 : 13107;
        c  = m_clip[i];
        xr = (hold * recip) >>> 16;
        x  = clampv(xr, -32768, 32767);
        if (x != xr) c = 1;
        yfr = (x - m_x1[i]) * 1024 + m_yf[i] - (m_yf[i] >>> 10);
        yf  = clampv(yfr, -YF_LIM, YF_LIM);
        if (yf != yfr) c = 1;
        m_x1[i] = x;
        m_yf[i] = yf;
        dr = yf >>> 10;
        d  = clampv(dr, -32768, 32767);
        if (d != dr) c = 1;
        if (mute) o = 0;
        else begin
            orr = (d * longint'(gain)) >>> 7;
            o   = clampv(orr, -32768, 32767);
            if (o != orr) c = 1;
        end
        m_clip[i] = c;
        exp_q.push_back('{i, o, c});
    endtask

    task automatic model_ce(input int i, input logic signed [15:0] s);
        int dec;
        dec = (i == 0) ? 73 : 5;
        m_acc[i] += longint'(s);
        if (m_cnt[i] == dec - 1) begin
            model_block(i, m_acc[i]);
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end else begin
            m_cnt[i]++;
        end
    endtask

    task automatic ce_pulse(input int i, input logic signed [15:0] s);
        @(negedge clk_sys);
        sample_in = s;
        if (i == 0) ce0 = 1'b1; else ce1 = 1'b1;
        model_ce(i, s);
        @(posedge clk_sys);
        #1;
        ce0 = 1'b0;
        ce1 = 1'b0;
    endtask

    task automatic block(input int i, input logic signed [15:0] s);
        for (int k = 0; k < ((i == 0) ? 73 : 5); k++) ce_pulse(i, s);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk_sys);
            n++;
        end
        @(negedge clk_sys);
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        model_reset();
        @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic handle(input int i, input longint o, input longint c);
        exp_t e;
        vcount[i]++;
        last_out[i] = o;
        if (exp_q.size() == 0) begin
            check("unexpected_valid", i, -1);
        end else begin
            e = exp_q.pop_front();
            check("valid_inst", i, e.inst);
            check("sample_out", o, e.val);
            check("clip", c, e.clp);
        end
    endtask

    always @(negedge clk_sys) begin
        if (val0) handle(0, out0, clip0);
        if (val1) handle(1, out1, clip1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v;
        reset = 1'b1; ce0 = 1'b0; ce1 = 1'b0; sample_in = '0; gain = 8'd128; mute = 1'b0;
        vcount[0] = 0; vcount[1] = 0; last_out[0] = 0; last_out[1] = 0;
        model_reset();
        #1;
        check("rst_out", out0, 0);
        check("rst_valid", val0, 0);
        check("rst_clip", clip0, 0);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;

        // Zero input: one output of 0, three cycles after the completing ce_in
        for (int k = 0; k < 73; k++) ce_pulse(0, 16'sd0);
        n = 0;
        while (!val0 && n < 10) begin
            @(posedge clk_sys);
            #1;
            n++;
        end
        check("latency", n, 3);
        drain();
        check("t1_out", last_out[0], 0);
        check("t1_clip", clip0, 0);
        check("t1_vcount", vcount[0], 1);

        // Step 1000 at unity gain, then long DC decay on the DECIM=5 build
        block(0, 16'sd1000);
        drain();
        check("t2_first", last_out[0], 1000);
        block(0, 16'sd1000);
        drain();
        check("t2_second", last_out[0], 999);
        for (int b = 0; b < 3072; b++) block(1, 16'sd1000);
        drain();
        check("t2_decay_lt60", (last_out[1] < 60 && last_out[1] >= 0), 1);
        check("t6_no_drop", vcount[1], 3072);

        // Full-scale input saturates the averager; clip is sticky
        do_reset();
        block(0, 16'sd32767);
        drain();
        check("t3_out", last_out[0], 32767);
        check("t3_clip", clip0, 1);
        block(0, 16'sd0);
        drain();
        check("t3_clip_sticky", clip0, 1);

        // DC-free blocks at gain 255 stay near zero; a 20000 step then clips
        do_reset();
        gain = 8'd255;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 72; k++) ce_pulse(0, (k % 2) ? -16'sd20000 : 16'sd20000);
            ce_pulse(0, 16'sd0);
        end
        drain();
        check("t4_dcfree", (last_out[0] <= 1 && last_out[0] >= -1), 1);
        check("t4_noclip", clip0, 0);
        block(0, 16'sd20000);
        drain();
        check("t4_step_out", last_out[0], 32767);
        check("t4_step_clip", clip0, 1);

        // Mute while the DC state keeps tracking, then unmute
        do_reset();
        gain = 8'd128;
        mute = 1'b1;
        v = vcount[0];
        for (int b = 0; b < 100; b++) block(0, 16'sd1000);
        drain();
        check("t5_muted_out", last_out[0], 0);
        check("t5_muted_count", vcount[0] - v, 100);
        mute = 1'b0;
        block(0, 16'sd1000);
        drain();
        check("t5_unmute_decayed", (last_out[0] >= 900 && last_out[0] <= 912), 1);

        // Reset mid-block discards the partial sum
        do_reset();
        for (int k = 0; k < 40; k++) ce_pulse(0, 16'sd1000);
        do_reset();
        v = vcount[0];
        for (int k = 0; k < 72; k++) ce_pulse(0, 16'sd1000);
        repeat (6) @(posedge clk_sys);
        @(negedge clk_sys);
        check("t6_no_early_valid", vcount[0] - v, 0);
        ce_pulse(0, 16'sd1000);
        drain();
        check("t6_valid_after_73", vcount[0] - v, 1);
        check("t6_out", last_out[0], 1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
